imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader: the writer side of the instruction memory that the single-cycle core reads through `PC`. It accepts a framed little-endian byte stream (header, program words, checksum) over a valid/ready handshake and writes each assembled 32-bit word into the instruction memory write port. It holds the core in reset via `core_hold` until a load completes with a matching checksum.

## Interface
- `ADDR_W`, default 8: instruction memory word-address width. Capacity is `MAX_WORDS = 2**ADDR_W`.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `areset`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: single-cycle pulse that requests a reload. Honoured only in RUN or ERR.
- `s_valid`, in, 1: input byte valid.
- `s_data`, in, 8: input byte.
- `s_ready`, out, 1: loader can accept a byte.
- `im_we`, out, 1: instruction memory write enable. Pulses for one cycle per word.
- `im_addr`, out, 32: byte address (word-aligned, same space as `PC`), equal to 4·index.
- `im_wdata`, out, 32: instruction word.
- `core_hold`, out, 1: keeps the core in reset while 1. Drive into the core's reset logic.
- `done`, out, 1: load finished with a good checksum.
- `err`, out, 1: load aborted (bad header or bad checksum).
- `word_cnt`, out, ADDR_W+1: number of words written in the current load.

## Operation
- A byte transfers on any cycle where `s_valid && s_ready`. Bytes with `s_ready`=0 are not consumed. The source must hold `s_data` until the transfer.
- A 2-bit byte counter and a 32-bit shift register assemble words: the k-th byte of a word goes to bits [8k+7:8k]. The 4th byte completes the word.
- State machine:
  - HDR: the completed word is N (program length in words).
    - N==0 or N>MAX_WORDS: go to ERR.
    - Otherwise latch N, clear index and checksum, go to DATA.
  - DATA: each completed word is written at `im_addr`=4·index, then index++ and `csum ^= word`.
    - When index reaches N, go to CSUM.
  - CSUM: the completed word is compared to `csum`.
    - Equal: go to RUN.
    - Not equal: go to ERR.
  - RUN: `s_ready`=0, `core_hold`=0, `done`=1.
    - `start` goes to HDR.
  - ERR: `s_ready`=0, `core_hold`=1, `err`=1.
    - `start` goes to HDR.
- `s_ready`=1 in HDR, DATA and CSUM. `core_hold`=1 in every state except RUN.
- On entry to HDR (from reset or `start`), clear all of the following: byte counter, shift register, index, `word_cnt`, `csum`, `done`, `err`.
- `start` is ignored in HDR, DATA and CSUM.
- Index arithmetic is ADDR_W+1 bits and never wraps, because N≤MAX_WORDS. `im_addr` = {index[ADDR_W-1:0], 2'b00}, zero-extended to 32 bits.

## Timing
- Reset values (`areset`=0 at a clock edge): state HDR, `s_ready`=1, `im_we`=0, `im_addr`=0, `im_wdata`=0, `core_hold`=1, `done`=0, `err`=0, `word_cnt`=0.
- Write latency: `im_we`, `im_addr` and `im_wdata` are registered. `im_we`=1 for exactly the cycle after the 4th byte of a DATA word transfers.
- Throughput: the loader sustains one byte per cycle. Back-to-back words produce `im_we` every 4th cycle.
- `word_cnt` updates in the same cycle as `im_we`.
- State-transition latency:
  - The state changes on the edge that accepts the 4th byte.
  - `done`, `err` and `core_hold` reflect the new state on the following cycle.
  - `s_ready` drops to 0 the cycle after the last CSUM byte.
- After a `start` pulse in RUN or ERR, the next cycle shows `core_hold`=1, `s_ready`=1 and `done`=`err`=0.
- Reset during DATA:
  - The partial word is discarded and no `im_we` is issued.
  - An `im_we` already registered for that edge is cleared by reset.
- Gaps in `s_valid` do not change state and do not reset the byte counter. There is no timeout.

## Structure
- Shared package `riscv_pkg`:
  - state encoding: HDR, DATA, CSUM, RUN, ERR
  - `BYTES_PER_WORD`=4
  - `HDR_LEN_BYTES`=4
- Sub-module `byte_packer`: byte counter, shift register, and a `word_valid` pulse on the 4th byte. It takes the same sync active-low reset plus a `clear` input driven on HDR entry.
- Top module `imem_loader`: FSM, index/`word_cnt`, checksum, registered memory write port.

## Test plan
- Good load (ADDR_W=8). Send bytes 02 00 00 00 | 93 00 50 00 | 13 81 10 00 | 80 81 40 00. Expected:
  - `im_we` at `im_addr`=0x0 with 0x00500093.
  - `im_we` at `im_addr`=0x4 with 0x00108113.
  - Then `done`=1, `core_hold`=0, `s_ready`=0, `word_cnt`=2.
- Bad checksum: same frame, last word bytes 81 81 40 00. Expected: both writes occur, then `err`=1, `core_hold`=1, `done`=0.
- Header limits:
  - N=0 (00 00 00 00): `err`=1, no `im_we`.
  - N=257 (01 01 00 00): `err`=1, no `im_we`.
  - N=256: accepted, last write at `im_addr`=0x3FC.
- Sparse `s_valid`: the good frame with 0–3 idle cycles between bytes gives identical writes and final state to the back-to-back case.
- Reset mid-word: `areset`=0 after 2 bytes of word 1. Expected: no `im_we`, then HDR with `word_cnt`=0 and `core_hold`=1. A full good frame afterwards loads correctly.
- Restart: `start` pulse in RUN. Next cycle `core_hold`=1, `done`=0, `s_ready`=1. A new frame overwrites from `im_addr`=0. A `start` pulse mid-DATA is ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared encodings and framing constants for the boot-time instruction memory loader.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } load_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_LEN_BYTES  = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;

    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        input  s_valid, s_data,
        output s_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid marks the cycle the 4th byte transfers.
module byte_packer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    always_ff @(posedge clk) begin
        if (!areset || clear) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    shreg[7:0]   <= byte_data;
                2'd1:    shreg[15:8]  <= byte_data;
                2'd2:    shreg[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // The top byte is taken straight from the bus so the word is usable on its completing cycle.
    assign word_valid = byte_en && (byte_cnt == LAST_BYTE);
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory writes; holds the core until a verified load.
//
// state   | meaning
// HDR     | collecting length word N
// DATA    | writing N program words, accumulating XOR checksum
// CSUM    | comparing received checksum word
// RUN     | load good, core released
// ERR     | bad header or checksum, core held
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int MAX_WORDS = 2 ** ADDR_W;

    load_state_t       state, state_nxt;
    logic [ADDR_W:0]   idx, idx_inc, n_len;
    logic [31:0]       csum;
    logic              im_we_q;
    logic [31:0]       im_addr_q, im_wdata_q;

    logic              byte_en, word_valid, start_ok, hdr_ok, wr_word, hdr_bad;
    logic [31:0]       word;

    assign bus.s_ready = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign byte_en     = bus.s_valid && bus.s_ready;
    assign idx_inc     = idx + 1'b1;
    assign hdr_bad     = (word == 32'd0) || (word > 32'(MAX_WORDS));

    byte_packer u_packer (
        .clk        (clk),
        .areset     (areset),
        .clear      (start_ok),
        .byte_en    (byte_en),
        .byte_data  (bus.s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        hdr_ok    = 1'b0;
        wr_word   = 1'b0;
        case (state)
            ST_HDR: begin
                if (word_valid) begin
                    hdr_ok    = !hdr_bad;
                    state_nxt = hdr_bad ? ST_ERR : ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    wr_word = 1'b1;
                    if (idx_inc == n_len) state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (word_valid) state_nxt = (word == csum) ? ST_RUN : ST_ERR;
            end
            ST_RUN, ST_ERR: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            state      <= ST_HDR;
            idx        <= '0;
            n_len      <= '0;
            csum       <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            im_we_q <= wr_word;
            if (start_ok || hdr_ok) begin
                idx  <= '0;
                csum <= '0;
            end
            if (hdr_ok) n_len <= word[ADDR_W:0];
            if (wr_word) begin
                idx        <= idx_inc;
                csum       <= csum ^ word;
                im_addr_q  <= {{(30 - ADDR_W){1'b0}}, idx[ADDR_W-1:0], 2'b00};
                im_wdata_q <= word;
            end
        end
    end

    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign word_cnt     = idx;
    assign core_hold    = (state != ST_RUN);
    assign done         = (state == ST_RUN);
    assign err          = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       areset;
    logic       start;
    logic       core_hold, done, err;
    logic [8:0] word_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(8)) dut (
        .clk       (clk),
        .areset    (areset),
        .start     (start),
        .bus       (bus),
        .core_hold (core_hold),
        .done      (done),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_addr.push_back(bus.im_addr);
            wr_data.push_back(bus.im_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int which, input int i);
        if (which == 0) return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxx_xxxx;
        else            return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (bus.s_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("s_ready_timeout", {31'b0, bus.s_ready}, 32'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8]);
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
    endtask

    task automatic send_good_frame(input int maxgap);
        send_word(32'h0000_0002, maxgap);
        send_word(32'h0050_0093, maxgap);
        send_word(32'h0010_8113, maxgap);
        send_word(32'h0040_8180, maxgap);
    endtask

    task automatic check_good(input string tag);
        check({tag, "_nwr"},   wr_addr.size(), 32'd2);
        check({tag, "_a0"},    q_at(0, 0), 32'h0000_0000);
        check({tag, "_d0"},    q_at(1, 0), 32'h0050_0093);
        check({tag, "_a1"},    q_at(0, 1), 32'h0000_0004);
        check({tag, "_d1"},    q_at(1, 1), 32'h0010_8113);
        check({tag, "_done"},  done, 1'b1);
        check({tag, "_hold"},  core_hold, 1'b0);
        check({tag, "_rdy"},   bus.s_ready, 1'b0);
        check({tag, "_err"},   err, 1'b0);
        check({tag, "_wcnt"},  word_cnt, 32'd2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] csum256;
        logic [31:0] w;

        areset      = 1'b0;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(negedge clk);

        check("rst_rdy",   bus.s_ready, 1'b1);
        check("rst_we",    bus.im_we, 1'b0);
        check("rst_addr",  bus.im_addr, 32'h0);
        check("rst_wdata", bus.im_wdata, 32'h0);
        check("rst_hold",  core_hold, 1'b1);
        check("rst_done",  done, 1'b0);
        check("rst_err",   err, 1'b0);
        check("rst_wcnt",  word_cnt, 32'd0);
        areset = 1'b1;
        @(negedge clk);

        // Good load, back-to-back bytes, with write-latency checks.
        clear_log();
        send_word(32'h0000_0002, 0);
        check("good_hdr_no_we", bus.im_we, 1'b0);
        send_word(32'h0050_0093, 0);
        check("good_w0_we",    bus.im_we, 1'b1);
        check("good_w0_addr",  bus.im_addr, 32'h0);
        check("good_w0_data",  bus.im_wdata, 32'h0050_0093);
        check("good_w0_wcnt",  word_cnt, 32'd1);
        send_word(32'h0010_8113, 0);
        check("good_w1_we",    bus.im_we, 1'b1);
        check("good_w1_wcnt",  word_cnt, 32'd2);
        check("good_hold_csum", core_hold, 1'b1);
        send_word(32'h0040_8180, 0);
        check_good("good");
        check("good_spacing", (wr_cyc.size() == 2) ? 32'(wr_cyc[1] - wr_cyc[0]) : 32'hffff_ffff, 32'd4);

        // Restart from RUN.
        pulse_start();
        check("rst_run_hold", core_hold, 1'b1);
        check("rst_run_done", done, 1'b0);
        check("rst_run_err",  err, 1'b0);
        check("rst_run_rdy",  bus.s_ready, 1'b1);
        check("rst_run_wcnt", word_cnt, 32'd0);

        // Bad checksum.
        clear_log();
        send_word(32'h0000_0002, 0);
        send_word(32'h0050_0093, 0);
        send_word(32'h0010_8113, 0);
        send_word(32'h0040_8181, 0);
        check("bad_nwr",  wr_addr.size(), 32'd2);
        check("bad_a1",   q_at(0, 1), 32'h4);
        check("bad_err",  err, 1'b1);
        check("bad_hold", core_hold, 1'b1);
        check("bad_done", done, 1'b0);
        check("bad_rdy",  bus.s_ready, 1'b0);

        // Restart from ERR, then N=0.
        pulse_start();
        check("rst_err_err", err, 1'b0);
        check("rst_err_rdy", bus.s_ready, 1'b1);
        clear_log();
        send_word(32'h0000_0000, 0);
        @(negedge clk);
        check("n0_err", err, 1'b1);
        check("n0_nwr", wr_addr.size(), 32'd0);

        // N=257.
        pulse_start();
        clear_log();
        send_word(32'h0000_0101, 0);
        @(negedge clk);
        check("n257_err", err, 1'b1);
        check("n257_nwr", wr_addr.size(), 32'd0);

        // N=256: full capacity.
        pulse_start();
        clear_log();
        csum256 = 32'h0;
        send_word(32'h0000_0100, 0);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(~i), 8'h5A, 8'(i * 3)};
            csum256 ^= w;
            send_word(w, 0);
        end
        send_word(csum256, 0);
        check("n256_nwr",   wr_addr.size(), 32'd256);
        check("n256_afirst", q_at(0, 0), 32'h0);
        check("n256_alast", q_at(0, 255), 32'h0000_03FC);
        check("n256_dlast", q_at(1, 255), {8'hFF, 8'h00, 8'h5A, 8'hFD});
        check("n256_wcnt",  word_cnt, 32'd256);
        check("n256_done",  done, 1'b1);

        // Sparse s_valid.
        pulse_start();
        clear_log();
        send_good_frame(3);
        check_good("sparse");

        // Reset after 2 bytes of word 1.
        pulse_start();
        clear_log();
        send_word(32'h0000_0002, 0);
        send_byte(8'h93);
        send_byte(8'h00);
        areset = 1'b0;
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        check("rstmid_nwr",  wr_addr.size(), 32'd0);
        check("rstmid_wcnt", word_cnt, 32'd0);
        check("rstmid_hold", core_hold, 1'b1);
        check("rstmid_rdy",  bus.s_ready, 1'b1);

        // Reset on the edge that takes the 4th byte: the pending write is cleared.
        send_word(32'h0000_0002, 0);
        send_byte(8'h93);
        send_byte(8'h00);
        send_byte(8'h50);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h00;
        areset      = 1'b0;
        @(negedge clk);
        bus.s_valid = 1'b0;
        areset      = 1'b1;
        check("rst4_we",   bus.im_we, 1'b0);
        check("rst4_nwr",  wr_addr.size(), 32'd0);
        check("rst4_wcnt", word_cnt, 32'd0);
        send_good_frame(0);
        check_good("after_rst");

        // start mid-DATA is ignored.
        pulse_start();
        clear_log();
        send_word(32'h0000_0002, 0);
        send_word(32'h0050_0093, 0);
        pulse_start();
        check("middata_hold", core_hold, 1'b1);
        check("middata_rdy",  bus.s_ready, 1'b1);
        check("middata_wcnt", word_cnt, 32'd1);
        send_word(32'h0010_8113, 0);
        send_word(32'h0040_8180, 0);
        check_good("middata");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
